// File: rtl/mux_scan_pkg.sv
// Shared types and index helpers for the bit-select mux scan sequencer.
package mux_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Index at which a scan ends: top bit when scanning up, bit 0 when scanning down.
  function automatic int unsigned term_idx(input int unsigned depth, input bit msb_first);
    return msb_first ? 32'd0 : depth - 32'd1;
  endfunction

  // Index at which a scan begins.
  function automatic int unsigned start_idx(input int unsigned depth, input bit msb_first);
    return msb_first ? depth - 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Sequencer that latches a word onto an external bit-select mux and walks the
// select across every bit, streaming each selected bit out with valid/ready/last.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned width     = 2,
  parameter int unsigned depth     = 4,
  parameter bit          msb_first = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [depth-1:0] s_data,
  output logic             s_ready,
  output logic [depth-1:0] mux_in,
  output logic [width-1:0] mux_sel,
  input  logic             mux_out,
  output logic             m_valid,
  output logic             m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy
);

  if (depth < 2 || depth > (1 << width)) begin : g_bad_params
    $error("mux_scan_ctrl: depth must satisfy 2 <= depth <= 2**width");
  end

  localparam logic [width-1:0] start_sel = width'(start_idx(depth, msb_first));
  localparam logic [width-1:0] term_sel  = width'(term_idx(depth, msb_first));

  scan_state_t      state;
  logic [width-1:0] next_sel;

  always_comb begin
    next_sel = msb_first ? mux_sel - width'(1) : mux_sel + width'(1);
  end

  // Ready comes straight from m_ready on the last beat so words chain without a bubble.
  assign s_ready = (state == IDLE) || (m_ready && m_last);
  assign m_data  = mux_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mux_in  <= '0;
      mux_sel <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            state   <= SCAN;
            mux_in  <= s_data;
            mux_sel <= start_sel;
            m_valid <= 1'b1;
            m_last  <= (start_sel == term_sel);
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (m_ready) begin
            if (m_last) begin
              if (s_valid) begin
                mux_in  <= s_data;
                mux_sel <= start_sel;
                m_last  <= (start_sel == term_sel);
              end else begin
                state   <= IDLE;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                busy    <= 1'b0;
              end
            end else begin
              mux_sel <= next_sel;
              m_last  <= (next_sel == term_sel);
            end
          end
        end
      endcase
    end
  end

endmodule
